bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3) for the reaction timer display path. It takes the binary elapsed-time count from the timer and produces packed BCD digits for the seven-segment multiplexer. Each conversion step uses one combinational `add3` cell per internal digit. A start/done handshake accepts one value at a time.

## Interface
- `BIN_W`, default 14: binary input width.
- `DIGITS`, default 4: number of BCD digits output. Constraint: 2^BIN_W ≤ 10^(DIGITS+1).
- `clk` input, 1 bit: system clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: request a conversion. Sampled only while `ready`=1.
- `bin` input, `BIN_W` bits: unsigned value. Sampled on the accepting edge only.
- `ready` output, 1 bit: idle and able to accept `start`.
- `done` output, 1 bit: single-cycle pulse when `bcd` is updated.
- `bcd` output, 4*`DIGITS` bits: packed result with digit 0 in bits [3:0]. Holds its value until the next completion.
- `overflow` output, 1 bit: set when the last result exceeded 10^`DIGITS`−1. Valid alongside `bcd`.

## Operation
- Internal registers:
  - Binary shift register, `BIN_W` bits.
  - BCD shift register, 4*(`DIGITS`+1) bits, which includes one guard digit.
  - Step counter, ceil(log2(`BIN_W`+1)) bits.
- FSM states and transitions:
  - IDLE: `ready`=1. On `start`=1, load the binary register from `bin`, clear the BCD register, clear the counter, and go to CONV.
  - CONV: `ready`=0. Each cycle, every internal digit passes through `add3` (digit ≥5 gets +3, result truncated to 4 bits). Then the concatenation {BCD, binary} shifts left by one, with the binary MSB entering the BCD LSB. The counter increments each cycle.
  - Finishing CONV: on the cycle performing step `BIN_W`, register the final value into `bcd`/`overflow`, pulse `done`, and return to IDLE.
- `start` asserted during CONV is ignored and not queued. `bin` changes during CONV have no effect.
- Result selection: `bcd` takes the low `DIGITS` digits of the final BCD register. `overflow` follows the rule in Configuration.
- Reset, including mid-conversion, forces the following; an aborted conversion produces no `done`:
  - state IDLE
  - `ready`=1
  - `done`=0
  - `bcd`=0
  - `overflow`=0
  - internal registers 0

## Timing
- Accepting edge E0: `start`=1 sampled with `ready`=1. `ready` is low from E0 onward.
- Edges E1..E`BIN_W` perform the `BIN_W` shift steps.
- Edge E`BIN_W` loads `bcd`/`overflow`, sets `done`=1, and sets `ready`=1.
- `done` deasserts at E`BIN_W`+1.
- Latency is `BIN_W` cycles from acceptance to `done` (14 cycles at defaults). Throughput is one conversion per `BIN_W`+1 cycles.
- Back-to-back operation: `start`=1 in the cycle where `done`=1 is accepted, because `ready`=1 in that cycle. The next conversion begins without an idle gap.
- `bcd` is registered. No combinational path exists from `bin`/`start` to any output.

## Configuration
- Macro `BCD_SAT_EN`.
- Defined: if the guard digit is nonzero at completion, `bcd` is all 9s (0x9999 at defaults) and `overflow`=1. Otherwise `overflow`=0.
- Undefined: `bcd` is the low `DIGITS` digits, i.e. the value mod 10^`DIGITS`. `overflow` is tied 0. The guard-digit comparison logic is not built.

## Test plan
- Reset, then `bin`=0, `start` pulse → `done` exactly 14 cycles after acceptance, `bcd`=0x0000, `overflow`=0, `ready` back to 1 with `done`.
- `bin`=1234 → `bcd`=0x1234. `bin`=9999 → `bcd`=0x9999, `overflow`=0.
- `bin`=16383: with `BCD_SAT_EN` → `bcd`=0x9999, `overflow`=1. Without it → `bcd`=0x6383, `overflow`=0.
- `bin`=500 accepted; `start`=1 with `bin`=42 pulsed at cycle 5 of CONV → second request ignored, `bcd`=0x0500, exactly one `done`.
- `bin`=250 accepted, `reset` asserted at cycle 7 → `done` never pulses, `bcd`=0x0000, `ready`=1 the cycle after reset. Next conversion of 77 → `bcd`=0x0077.
- Back-to-back: `start` held high with `bin`=321 then 4095 → `done` pulses 15 cycles apart, `bcd`=0x0321 then 0x4095.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   It converts the timer's binary elapsed-time count into packed BCD digits
//   for the seven-segment multiplexer. One shift step is done per clock. A
//   start/ready handshake accepts a single value at a time.
//
// Parameters
//   BIN_W   binary input width (default 14)
//   DIGITS  number of BCD digits on bcd_o (default 4).
//           Must satisfy 2^BIN_W <= 10^(DIGITS+1).
//
// Ports
//   clk_i       system clock; all state changes on the rising edge
//   reset_i     synchronous, active-high reset
//   start_i     conversion request; only sampled while ready_o = 1
//   bin_i       unsigned binary value; only sampled on the accepting edge
//   ready_o     idle and able to accept start_i
//   done_o      one-cycle pulse in the cycle that bcd_o is updated
//   bcd_o       packed BCD result with digit 0 in bits [3:0]; holds its value
//               until the next completion
//   overflow_o  the last result exceeded 10^DIGITS-1 (saturating build only)
//
// Build option
//   BCD_SAT_EN  when defined: a nonzero guard digit at completion saturates
//               bcd_o to all 9s and sets overflow_o. When undefined: bcd_o is
//               the value mod 10^DIGITS, overflow_o is tied 0, and no
//               guard-digit compare logic is built.
// -----------------------------------------------------------------------------

// One add-3 correction cell: a digit of 5 or more gets +3 so that the next
// left shift carries correctly into the digit above.
module bin2bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;
endmodule

module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  overflow_o
);

  // The BCD shift register carries one guard digit above the visible digits.
  localparam int BCD_W = 4 * (DIGITS + 1);
  localparam int OUT_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q,   bin_d;
  logic [BCD_W-1:0]   sh_q,    sh_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [OUT_W-1:0]   bcd_q,   bcd_d;
  logic               ovf_q,   ovf_d;
  logic               done_q,  done_d;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   step_bcd;
  logic [BIN_W-1:0]   step_bin;
  logic               last_step;
  logic [OUT_W-1:0]   res_bcd;
  logic               res_ovf;

  // Add-3 correction on every digit, guard digit included.
  for (genvar g = 0; g <= DIGITS; g++) begin : g_add3
    bin2bcd_add3 u_add3 (
      .d_i (sh_q[4*g +: 4]),
      .d_o (adj[4*g +: 4])
    );
  end

  // {BCD, binary} shifted left by one; binary MSB enters the BCD LSB.
  assign step_bcd  = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
  assign step_bin  = {bin_q[BIN_W-2:0], 1'b0};

  // The counter holds the number of steps already done, so the step being
  // performed when it reads BIN_W-1 is the final one.
  assign last_step = (cnt_q == CNT_W'(BIN_W - 1));

`ifdef BCD_SAT_EN
  logic guard_nz;
  assign guard_nz = (step_bcd[BCD_W-1 -: 4] != 4'd0);
  assign res_bcd  = guard_nz ? {DIGITS{4'h9}} : step_bcd[OUT_W-1:0];
  assign res_ovf  = guard_nz;
`else
  assign res_bcd  = step_bcd[OUT_W-1:0];
  assign res_ovf  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          bin_d   = bin_i;
          sh_d    = '0;
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end

      S_CONV: begin
        bin_d = step_bin;
        sh_d  = step_bcd;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) begin
          bcd_d   = res_bcd;
          ovf_d   = res_ovf;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // All outputs come straight from registers.
  assign ready_o    = (state_q == S_IDLE);
  assign done_o     = done_q;
  assign bcd_o      = bcd_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;
  localparam int LAT    = BIN_W;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic                start_i;
  logic [BIN_W-1:0]    bin_i;
  logic                ready_o;
  logic                done_o;
  logic [4*DIGITS-1:0] bcd_o;
  logic                overflow_o;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc = 0;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .bin_i      (bin_i),
    .ready_o    (ready_o),
    .done_o     (done_o),
    .bcd_o      (bcd_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;
  always @(negedge clk_i) if (done_o) done_cnt++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: decimal arithmetic, then pack each decimal digit into a nibble.
  function automatic logic [16:0] model(input int v);
    int m;
    logic [15:0] b;
    logic o;
    o = 1'b0;
    m = v % 10000;
`ifdef BCD_SAT_EN
    if (v > 9999) begin
      m = 9999;
      o = 1'b1;
    end
`endif
    b = '0;
    for (int k = 0; k < DIGITS; k++) begin
      b[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {o, b};
  endfunction

  // Wait for done_o, at most 40 cycles; n = cycles waited.
  task automatic wait_done(output int n);
    n = 0;
    while (done_o !== 1'b1 && n < 40) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (done_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout: done never seen after %0d cycles", n);
    end
  endtask

  task automatic run_conv(input int v, output logic [15:0] b, output logic o,
                          output int lat);
    @(negedge clk_i);
    bin_i   = BIN_W'(v);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    bin_i   = '0;
    chk("ready_low_after_accept", int'(ready_o), 0);
    wait_done(lat);
    b = bcd_o;
    o = overflow_o;
  endtask

  typedef struct {
    int          v;
    logic [15:0] eb;
    logic        eo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [15:0] b;
    logic        o;
    logic [16:0] e;
    int          lat, d0, t0, t1, t2;

    vecs[0] = '{0,     16'h0000, 1'b0};
    vecs[1] = '{1234,  16'h1234, 1'b0};
    vecs[2] = '{9999,  16'h9999, 1'b0};
`ifdef BCD_SAT_EN
    vecs[3] = '{16383, 16'h9999, 1'b1};
    vecs[4] = '{10000, 16'h9999, 1'b1};
`else
    vecs[3] = '{16383, 16'h6383, 1'b0};
    vecs[4] = '{10000, 16'h0000, 1'b0};
`endif
    vecs[5] = '{1,     16'h0001, 1'b0};
    vecs[6] = '{10,    16'h0010, 1'b0};
    vecs[7] = '{8191,  16'h8191, 1'b0};

    reset_i = 1'b1;
    start_i = 1'b0;
    bin_i   = '0;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;
    chk("reset_ready", int'(ready_o), 1);
    chk("reset_done",  int'(done_o), 0);
    chk("reset_bcd",   int'(bcd_o), 0);
    chk("reset_ovf",   int'(overflow_o), 0);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_conv(vecs[i].v, b, o, lat);
      chk($sformatf("vec%0d_latency", i), lat, LAT);
      chk($sformatf("vec%0d_bcd", i), int'(b), int'(vecs[i].eb));
      chk($sformatf("vec%0d_ovf", i), int'(o), int'(vecs[i].eo));
      chk($sformatf("vec%0d_ready_with_done", i), int'(ready_o), 1);
      @(posedge clk_i); #1;
      chk($sformatf("vec%0d_done_one_cycle", i), int'(done_o), 0);
      chk($sformatf("vec%0d_bcd_hold", i), int'(bcd_o), int'(vecs[i].eb));
    end

    // Random values against the model
    for (int i = 0; i < 30; i++) begin
      int v;
      v = int'($urandom_range(0, (1 << BIN_W) - 1));
      run_conv(v, b, o, lat);
      e = model(v);
      chk($sformatf("rnd%0d_bcd(v=%0d)", i, v), int'(b), int'(e[15:0]));
      chk($sformatf("rnd%0d_ovf(v=%0d)", i, v), int'(o), int'(e[16]));
      chk($sformatf("rnd%0d_latency", i), lat, LAT);
    end

    // start during CONV is ignored
    @(negedge clk_i);
    bin_i = 14'd500; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (4) begin @(posedge clk_i); #1; end
    bin_i = 14'd42; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    d0 = done_cnt;
    wait_done(lat);
    chk("ignore_bcd", int'(bcd_o), 16'h0500);
    repeat (20) begin @(posedge clk_i); #1; end
    chk("ignore_single_done", done_cnt - d0, 1);
    chk("ignore_ready_idle", int'(ready_o), 1);
    chk("ignore_bcd_hold", int'(bcd_o), 16'h0500);

    // Reset mid-conversion aborts silently
    @(negedge clk_i);
    bin_i = 14'd250; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (6) begin @(posedge clk_i); #1; end
    d0 = done_cnt;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    chk("abort_ready", int'(ready_o), 1);
    chk("abort_bcd", int'(bcd_o), 0);
    chk("abort_ovf", int'(overflow_o), 0);
    repeat (20) begin @(posedge clk_i); #1; end
    chk("abort_no_done", done_cnt - d0, 0);
    run_conv(77, b, o, lat);
    chk("after_abort_bcd", int'(b), 16'h0077);
    chk("after_abort_latency", lat, LAT);

    // Back-to-back with start held high
    @(negedge clk_i);
    bin_i = 14'd321; start_i = 1'b1;
    @(posedge clk_i); #1;
    t0 = cyc;
    bin_i = 14'd4095;
    wait_done(lat);
    t1 = cyc;
    chk("b2b_first_bcd", int'(bcd_o), 16'h0321);
    chk("b2b_first_latency", t1 - t0, LAT);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("b2b_second_accepted", int'(ready_o), 0);
    wait_done(lat);
    t2 = cyc;
    chk("b2b_done_spacing", t2 - t1, LAT + 1);
    chk("b2b_second_bcd", int'(bcd_o), 16'h4095);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
